// File: rtl/minmax_window8_pkg.sv
// Shared constants, state encoding and sizing helper for the windowed min/max tracker.
// The 8-bit datapath width and the running-extreme sentinels live here.
package minmax_window8_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] MIN_INIT = 8'hFF;
    localparam logic [DATA_W-1:0] MAX_INIT = 8'h00;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Counter width for a window of n samples; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/minmax_window8_if.sv
// Sample-in / result-out handshake bundle for minmax_window8.
// The master side produces samples and consumes results; the slave side is the tracker.
interface minmax_window8_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] I_DATA;
    logic             I_VALID;
    logic             I_READY;
    logic [WIDTH-1:0] O_MIN;
    logic [WIDTH-1:0] O_MAX;
    logic             O_VALID;
    logic             O_READY;

    modport master (
        output I_DATA, I_VALID, O_READY,
        input  I_READY, O_MIN, O_MAX, O_VALID
    );

    modport slave (
        input  I_DATA, I_VALID, O_READY,
        output I_READY, O_MIN, O_MAX, O_VALID
    );
endinterface

// File: rtl/minmax_update8.sv
// Combinational running-extreme update: folds one sample into the stored min and max.
// Ties pick the sample, which is indistinguishable from keeping the equal stored value.
module minmax_update8
    import minmax_window8_pkg::*;
(
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] run_min,
    input  logic [DATA_W-1:0] run_max,
    output logic [DATA_W-1:0] new_min,
    output logic [DATA_W-1:0] new_max
);
    logic sample_le_min;
    logic max_le_sample;

    ule8_cmp u_cmp_min (
        .a  (sample),
        .b  (run_min),
        .le (sample_le_min)
    );

    ule8_cmp u_cmp_max (
        .a  (run_max),
        .b  (sample),
        .le (max_le_sample)
    );

    assign new_min = sample_le_min ? sample : run_min;
    assign new_max = max_le_sample ? sample : run_max;
endmodule

// File: rtl/ule8_cmp.sv
// 8-bit unsigned less-or-equal comparator built as a ripple carry chain.
// le = (a <= b), taken as the carry-out of b + ~a + 1 (no borrow means b >= a).
module ule8_cmp
    import minmax_window8_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              le
);
    logic [DATA_W:0] carry;

    assign carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_chain
            assign carry[gi+1] = (b[gi] & ~a[gi]) | ((b[gi] ^ ~a[gi]) & carry[gi]);
        end
    endgenerate

    assign le = carry[DATA_W];
endmodule

// File: rtl/minmax_window8.sv
// Windowed running min/max tracker: after WINDOW accepted samples it presents the
// window's extremes on a one-deep valid/ready result register, then starts again.
module minmax_window8
    import minmax_window8_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLR,
    minmax_window8_if.slave   bus
);
    localparam int              CNT_W    = cnt_width(WINDOW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   run_min_reg;
    logic [WIDTH-1:0]   run_max_reg;
    logic [WIDTH-1:0]   o_min_reg;
    logic [WIDTH-1:0]   o_max_reg;
    logic [WIDTH-1:0]   new_min;
    logic [WIDTH-1:0]   new_max;
    logic               ready;
    logic               accept;
    logic               last;

    // The only combinational path: a consumer taking the result frees the input this cycle.
    assign ready  = !CLR && (state_reg == ACCUM || bus.O_READY);
    assign accept = bus.I_VALID && ready;
    assign last   = (cnt_reg == CNT_LAST);

    assign bus.I_READY = ready;
    assign bus.O_MIN   = o_min_reg;
    assign bus.O_MAX   = o_max_reg;
    assign bus.O_VALID = (state_reg == HOLD);

    minmax_update8 u_update (
        .sample  (bus.I_DATA),
        .run_min (run_min_reg),
        .run_max (run_max_reg),
        .new_min (new_min),
        .new_max (new_max)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= ACCUM;
            cnt_reg     <= '0;
            run_min_reg <= MIN_INIT;
            run_max_reg <= MAX_INIT;
            o_min_reg   <= '0;
            o_max_reg   <= '0;
        end else begin
            if (state_reg == HOLD && bus.O_READY) begin
                state_reg <= ACCUM;
            end

            if (CLR) begin
                cnt_reg     <= '0;
                run_min_reg <= MIN_INIT;
                run_max_reg <= MAX_INIT;
            end else if (accept) begin
                if (last) begin
                    // Final sample: load the result (overriding a same-cycle consume).
                    o_min_reg   <= new_min;
                    o_max_reg   <= new_max;
                    state_reg   <= HOLD;
                    cnt_reg     <= '0;
                    run_min_reg <= MIN_INIT;
                    run_max_reg <= MAX_INIT;
                end else begin
                    run_min_reg <= new_min;
                    run_max_reg <= new_max;
                    cnt_reg     <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_minmax_window8.sv
// Drives WINDOW=4, 2 and 1 trackers with shared stimulus and checks each against a
// list-based window model every cycle.
module tb_minmax_window8;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       drv_valid;
    logic       drv_oready;
    logic [7:0] drv_data;

    always #5 clk = ~clk;

    logic       got_rdy [3];
    logic       got_vld [3];
    logic [7:0] got_min [3];
    logic [7:0] got_max [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            minmax_window8_if #(.WIDTH(8)) bus ();

            assign bus.I_DATA  = drv_data;
            assign bus.I_VALID = drv_valid;
            assign bus.O_READY = drv_oready;

            minmax_window8 #(.WIDTH(8), .WINDOW(4 >> gi)) dut (
                .CLK   (clk),
                .RESET (rst),
                .CLR   (clr),
                .bus   (bus)
            );

            assign got_rdy[gi] = bus.I_READY;
            assign got_vld[gi] = bus.O_VALID;
            assign got_min[gi] = bus.O_MIN;
            assign got_max[gi] = bus.O_MAX;
        end
    endgenerate

    // Model: the samples of the open window are kept as a list; extremes are
    // computed over the whole list once it holds WINDOW entries.
    int         m_n    [3];
    logic       m_pend [3];
    logic [7:0] m_min  [3];
    logic [7:0] m_max  [3];
    logic [7:0] m_buf  [3][256];

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_n[k]    = 0;
            m_pend[k] = 1'b0;
            m_min[k]  = 8'h00;
            m_max[k]  = 8'h00;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            int   w;
            logic rdy;
            logic [7:0] mn, mx;
            w = 4 >> k;
            if (rst) begin
                m_n[k]    = 0;
                m_pend[k] = 1'b0;
                m_min[k]  = 8'h00;
                m_max[k]  = 8'h00;
            end else begin
                rdy = !clr && (!m_pend[k] || drv_oready);
                if (m_pend[k] && drv_oready) m_pend[k] = 1'b0;
                if (clr) begin
                    m_n[k] = 0;
                end else if (drv_valid && rdy) begin
                    m_buf[k][m_n[k]] = drv_data;
                    m_n[k]++;
                    if (m_n[k] == w) begin
                        mn = 8'hFF;
                        mx = 8'h00;
                        for (int i = 0; i < w; i++) begin
                            if (m_buf[k][i] < mn) mn = m_buf[k][i];
                            if (m_buf[k][i] > mx) mx = m_buf[k][i];
                        end
                        m_min[k]  = mn;
                        m_max[k]  = mx;
                        m_pend[k] = 1'b1;
                        m_n[k]    = 0;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input logic [7:0] d, input logic v, input logic ordy,
                       input logic c, input logic r);
        drv_data   = d;
        drv_valid  = v;
        drv_oready = ordy;
        clr        = c;
        rst        = r;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            string pfx;
            pfx = $sformatf("W%0d", 4 >> k);
            chk({pfx, " i_ready"}, 32'(got_rdy[k]), 32'(!clr && (!m_pend[k] || drv_oready)));
            chk({pfx, " o_valid"}, 32'(got_vld[k]), 32'(m_pend[k]));
            chk({pfx, " o_min"},   32'(got_min[k]), 32'(m_min[k]));
            chk({pfx, " o_max"},   32'(got_max[k]), 32'(m_max[k]));
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        do_reset();
        do_reset();

        // Mixed window, then extremes and an all-equal window.
        cyc(8'd10, 1, 1, 0, 0); cyc(8'd3, 1, 1, 0, 0);
        cyc(8'd200, 1, 1, 0, 0); cyc(8'd3, 1, 1, 0, 0);
        idle(2);
        cyc(8'h00, 1, 1, 0, 0); cyc(8'hFF, 1, 1, 0, 0);
        cyc(8'h80, 1, 1, 0, 0); cyc(8'h80, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cyc(8'h7F, 1, 1, 0, 0);
        idle(2);

        // Stalled consumer: the result is held and input back-pressured.
        do_reset();
        cyc(8'd5, 1, 1, 0, 0); cyc(8'd9, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(8'd1, 1, 0, 0, 0);
        cyc(8'd1, 1, 1, 0, 0); cyc(8'd2, 1, 1, 0, 0);
        idle(2);

        // Continuous load plus consume.
        cyc(8'd4, 1, 1, 0, 0); cyc(8'd8, 1, 1, 0, 0); cyc(8'd2, 1, 1, 0, 0);
        idle(2);

        // Abort mid-window with a sample offered during CLR.
        do_reset();
        cyc(8'd50, 1, 1, 0, 0); cyc(8'd60, 1, 1, 0, 0);
        cyc(8'd99, 1, 1, 1, 0);
        for (int i = 1; i <= 4; i++) cyc(8'(i), 1, 1, 0, 0);
        idle(2);

        // Reset mid-window with results pending.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(8'd9, 1, 0, 0, 0);
        cyc(8'h00, 0, 0, 0, 1);
        cyc(8'd20, 1, 1, 0, 0); cyc(8'd7, 1, 1, 0, 0);
        cyc(8'd30, 1, 1, 0, 0); cyc(8'd15, 1, 1, 0, 0);
        idle(2);

        // Randomised traffic, biased toward the 00/FF extremes.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] d;
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            else d = 8'($urandom);
            cyc(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 30) == 0, $urandom_range(0, 200) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
